gato_arbitro_turnos: RTL and testbench

- Downstream stage of the tic-tac-toe cell selector.
- Consumes the nine 2-bit cell registers and the p1_mm/p2_mm "player moved" flags, then decides whose turn is next, detects wins and draws, and enforces a per-turn timeout.
- Drives turno_p1/turno_p2 back into the selector and feeds the display/score logic.

---
 rtl/gato_arbitro_turnos.sv | 217 +++++++++++++++++++++
 tb/tb_gato_arbitro_turnos.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gato_arbitro_turnos.sv
// Tic-tac-toe turn arbiter: decides whose turn it is, detects wins and draws,
// and forfeits a turn that runs out of time.
module gato_arbitro_turnos #(
    parameter int unsigned TIEMPO_TURNO = 50_000_000,
    parameter int unsigned ANCHO_T      = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nuevo_juego,
    input  logic [1:0] guarda_c1,
    input  logic [1:0] guarda_c2,
    input  logic [1:0] guarda_c3,
    input  logic [1:0] guarda_c4,
    input  logic [1:0] guarda_c5,
    input  logic [1:0] guarda_c6,
    input  logic [1:0] guarda_c7,
    input  logic [1:0] guarda_c8,
    input  logic [1:0] guarda_c9,
    input  logic       p1_mm,
    input  logic       p2_mm,
    output logic       turno_p1,
    output logic       turno_p2,
    output logic       gana_p1,
    output logic       gana_p2,
    output logic       empate,
    output logic       fin_juego,
    output logic [3:0] linea_ganadora,
    output logic [3:0] jugadas,
    output logic       tiempo_agotado
);

    localparam int unsigned ANCHO_TAB = 18;
    localparam logic [1:0]  SIMB_P1   = 2'b11;
    localparam logic [1:0]  SIMB_P2   = 2'b01;

    typedef enum logic [2:0] {TURNO_P1, TURNO_P2, ESPERA, EVALUA, FIN} estado_t;

    estado_t estado_q, estado_d;

    logic [ANCHO_TAB-1:0] tab_meta_q, tab_sync_q;
    logic [1:0]           mm_meta_q, mm_sync_q, mm_prev_q;
    logic                 p1_flanco, p2_flanco;

    logic [ANCHO_T-1:0]   timer_q, timer_d;
    logic                 expira;
    logic                 mover_q, mover_d;          // 0 = P1, 1 = P2
    logic [3:0]           jugadas_q, jugadas_d, jugadas_inc;
    logic [3:0]           linea_q, linea_d, linea_enc;
    logic                 turno_p1_q, turno_p1_d, turno_p2_q, turno_p2_d;
    logic                 gana_p1_q, gana_p1_d, gana_p2_q, gana_p2_d;
    logic                 empate_q, empate_d, fin_q, fin_d;
    logic                 tiempo_q, tiempo_d;

    // Cell k (1..9) of the packed board
    function automatic logic [1:0] celda(input logic [ANCHO_TAB-1:0] t, input int k);
        return t[2*(k-1) +: 2];
    endfunction

    // Lowest-numbered line fully held by symbol s, 0 when none
    function automatic logic [3:0] busca_linea(input logic [ANCHO_TAB-1:0] t, input logic [1:0] s);
        logic [7:0] m;
        logic [3:0] r;
        m[0] = (celda(t, 1) == s) && (celda(t, 2) == s) && (celda(t, 3) == s);
        m[1] = (celda(t, 4) == s) && (celda(t, 5) == s) && (celda(t, 6) == s);
        m[2] = (celda(t, 7) == s) && (celda(t, 8) == s) && (celda(t, 9) == s);
        m[3] = (celda(t, 1) == s) && (celda(t, 4) == s) && (celda(t, 7) == s);
        m[4] = (celda(t, 2) == s) && (celda(t, 5) == s) && (celda(t, 8) == s);
        m[5] = (celda(t, 3) == s) && (celda(t, 6) == s) && (celda(t, 9) == s);
        m[6] = (celda(t, 1) == s) && (celda(t, 5) == s) && (celda(t, 9) == s);
        m[7] = (celda(t, 3) == s) && (celda(t, 5) == s) && (celda(t, 7) == s);
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 4'(i + 1);
        end
        return r;
    endfunction

    // Two-flop synchronisers for the board and move flags, plus edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            tab_meta_q <= '0;
            tab_sync_q <= '0;
            mm_meta_q  <= '0;
            mm_sync_q  <= '0;
            mm_prev_q  <= '0;
        end else begin
            tab_meta_q <= {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                           guarda_c4, guarda_c3, guarda_c2, guarda_c1};
            tab_sync_q <= tab_meta_q;
            mm_meta_q  <= {p2_mm, p1_mm};
            mm_sync_q  <= mm_meta_q;
            mm_prev_q  <= mm_sync_q;
        end
    end

    assign p1_flanco   = mm_sync_q[0] & ~mm_prev_q[0];
    assign p2_flanco   = mm_sync_q[1] & ~mm_prev_q[1];
    assign expira      = (timer_q == ANCHO_T'(TIEMPO_TURNO - 1));
    assign jugadas_inc = (jugadas_q >= 4'd9) ? 4'd9 : jugadas_q + 4'd1;
    assign linea_enc   = busca_linea(tab_sync_q, mover_q ? SIMB_P2 : SIMB_P1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) estado_q <= TURNO_P1;
        else       estado_q <= estado_d;
    end

    // Next-state logic; a move edge takes precedence over timer expiry
    always_comb begin
        estado_d = estado_q;
        if (nuevo_juego) begin
            estado_d = TURNO_P1;
        end else begin
            case (estado_q)
                TURNO_P1: if (p1_flanco) estado_d = ESPERA;
                          else if (expira) estado_d = TURNO_P2;
                TURNO_P2: if (p2_flanco) estado_d = ESPERA;
                          else if (expira) estado_d = TURNO_P1;
                ESPERA:   estado_d = EVALUA;
                EVALUA:   if ((linea_enc != 4'd0) || (jugadas_inc == 4'd9)) estado_d = FIN;
                          else estado_d = mover_q ? TURNO_P1 : TURNO_P2;
                FIN:      estado_d = FIN;
                default:  estado_d = TURNO_P1;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        timer_d    = timer_q;
        mover_d    = mover_q;
        jugadas_d  = jugadas_q;
        linea_d    = linea_q;
        gana_p1_d  = gana_p1_q;
        gana_p2_d  = gana_p2_q;
        empate_d   = empate_q;
        tiempo_d   = 1'b0;
        if (nuevo_juego) begin
            timer_d   = '0;
            mover_d   = 1'b0;
            jugadas_d = 4'd0;
            linea_d   = 4'd0;
            gana_p1_d = 1'b0;
            gana_p2_d = 1'b0;
            empate_d  = 1'b0;
        end else begin
            case (estado_q)
                TURNO_P1, TURNO_P2: begin
                    if ((estado_q == TURNO_P1) ? p1_flanco : p2_flanco) begin
                        mover_d = (estado_q == TURNO_P2);
                    end else if (expira) begin
                        timer_d  = '0;
                        tiempo_d = 1'b1;
                    end else begin
                        timer_d = timer_q + ANCHO_T'(1);
                    end
                end
                EVALUA: begin
                    jugadas_d = jugadas_inc;
                    if (linea_enc != 4'd0) begin
                        linea_d   = linea_enc;
                        gana_p1_d = ~mover_q;
                        gana_p2_d = mover_q;
                    end else if (jugadas_inc == 4'd9) begin
                        empate_d = 1'b1;
                    end else begin
                        timer_d = '0;
                    end
                end
                default: ;
            endcase
        end
        turno_p1_d = (estado_d == TURNO_P1);
        turno_p2_d = (estado_d == TURNO_P2);
        fin_d      = gana_p1_d | gana_p2_d | empate_d;
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q    <= '0;
            mover_q    <= 1'b0;
            jugadas_q  <= 4'd0;
            linea_q    <= 4'd0;
            gana_p1_q  <= 1'b0;
            gana_p2_q  <= 1'b0;
            empate_q   <= 1'b0;
            fin_q      <= 1'b0;
            tiempo_q   <= 1'b0;
            turno_p1_q <= 1'b1;
            turno_p2_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            mover_q    <= mover_d;
            jugadas_q  <= jugadas_d;
            linea_q    <= linea_d;
            gana_p1_q  <= gana_p1_d;
            gana_p2_q  <= gana_p2_d;
            empate_q   <= empate_d;
            fin_q      <= fin_d;
            tiempo_q   <= tiempo_d;
            turno_p1_q <= turno_p1_d;
            turno_p2_q <= turno_p2_d;
        end
    end

    assign turno_p1       = turno_p1_q;
    assign turno_p2       = turno_p2_q;
    assign gana_p1        = gana_p1_q;
    assign gana_p2        = gana_p2_q;
    assign empate         = empate_q;
    assign fin_juego      = fin_q;
    assign linea_ganadora = linea_q;
    assign jugadas        = jugadas_q;
    assign tiempo_agotado = tiempo_q;

endmodule

// File: tb/tb_gato_arbitro_turnos.sv
// Directed bench for the tic-tac-toe turn arbiter (short turn timeout of 16 cycles).
module tb_gato_arbitro_turnos;

    logic       clk = 1'b0;
    logic       reset, nuevo_juego, p1_mm, p2_mm;
    logic [1:0] cel [1:9];
    logic       turno_p1, turno_p2, gana_p1, gana_p2, empate, fin_juego, tiempo_agotado;
    logic [3:0] linea_ganadora, jugadas;

    int total  = 0;
    int pasado = 0;

    always #5 clk = ~clk;

    gato_arbitro_turnos #(.TIEMPO_TURNO(16), .ANCHO_T(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .nuevo_juego    (nuevo_juego),
        .guarda_c1      (cel[1]),
        .guarda_c2      (cel[2]),
        .guarda_c3      (cel[3]),
        .guarda_c4      (cel[4]),
        .guarda_c5      (cel[5]),
        .guarda_c6      (cel[6]),
        .guarda_c7      (cel[7]),
        .guarda_c8      (cel[8]),
        .guarda_c9      (cel[9]),
        .p1_mm          (p1_mm),
        .p2_mm          (p2_mm),
        .turno_p1       (turno_p1),
        .turno_p2       (turno_p2),
        .gana_p1        (gana_p1),
        .gana_p2        (gana_p2),
        .empate         (empate),
        .fin_juego      (fin_juego),
        .linea_ganadora (linea_ganadora),
        .jugadas        (jugadas),
        .tiempo_agotado (tiempo_agotado)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) pasado++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Mark a cell and raise the mover's flag; the result settles 5 edges later
    task automatic jugar(input int c, input int p);
        cel[c] = (p == 1) ? 2'b11 : 2'b01;
        if (p == 1) p1_mm = 1'b1;
        else        p2_mm = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        p1_mm = 1'b0;
        p2_mm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic nuevo();
        for (int i = 1; i <= 9; i++) cel[i] = 2'b00;
        p1_mm = 1'b0;
        p2_mm = 1'b0;
        nuevo_juego = 1'b1;
        @(posedge clk);
        #1;
        nuevo_juego = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic g1, input logic g2, input logic em,
                           input logic [3:0] lin, input logic [3:0] jug);
        chk({tag, ".gana_p1"}, 4'(gana_p1), 4'(g1));
        chk({tag, ".gana_p2"}, 4'(gana_p2), 4'(g2));
        chk({tag, ".empate"},  4'(empate), 4'(em));
        chk({tag, ".fin"},     4'(fin_juego), 4'(g1 | g2 | em));
        chk({tag, ".linea"},   linea_ganadora, lin);
        chk({tag, ".jugadas"}, jugadas, jug);
    endtask

    initial begin
        reset = 1'b1;
        nuevo_juego = 1'b0;
        p1_mm = 1'b0;
        p2_mm = 1'b0;
        for (int i = 1; i <= 9; i++) cel[i] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst.turno_p1", 4'(turno_p1), 4'd1);
        chk("rst.turno_p2", 4'(turno_p2), 4'd0);
        chk("rst.tiempo", 4'(tiempo_agotado), 4'd0);
        chk_res("rst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Row-1 win, first move traced edge by edge for latency
        cel[1] = 2'b11;
        p1_mm = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lat.turno_p1_hold", 4'(turno_p1), 4'd1);
        @(posedge clk);
        #1;
        chk("lat.turno_p1_drop", 4'(turno_p1), 4'd0);
        chk("lat.turno_p2_espera", 4'(turno_p2), 4'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("lat.turno_p2", 4'(turno_p2), 4'd1);
        chk("lat.jugadas", jugadas, 4'd1);
        p1_mm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        jugar(4, 2); jugar(2, 1); jugar(5, 2); jugar(3, 1);
        chk_res("fila1", 1'b1, 1'b0, 1'b0, 4'd1, 4'd5);
        chk("fila1.turno_p1", 4'(turno_p1), 4'd0);
        chk("fila1.turno_p2", 4'(turno_p2), 4'd0);

        // Draw
        nuevo();
        chk_res("nuevo", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        jugar(1, 1); jugar(2, 2); jugar(3, 1); jugar(5, 2); jugar(4, 1);
        jugar(6, 2); jugar(8, 1); jugar(7, 2); jugar(9, 1);
        chk_res("empate", 1'b0, 1'b0, 1'b1, 4'd0, 4'd9);

        // Timeout on P1's turn, then P2 may move
        nuevo();
        repeat (15) @(posedge clk);
        #1;
        chk("to.antes", 4'(tiempo_agotado), 4'd0);
        @(posedge clk);
        #1;
        chk("to.pulso", 4'(tiempo_agotado), 4'd1);
        chk("to.turno_p2", 4'(turno_p2), 4'd1);
        chk("to.turno_p1", 4'(turno_p1), 4'd0);
        chk("to.jugadas", jugadas, 4'd0);
        @(posedge clk);
        #1;
        chk("to.fin_pulso", 4'(tiempo_agotado), 4'd0);
        jugar(1, 2);
        chk("to.p2_acepta", jugadas, 4'd1);
        chk("to.turno_p1_vuelve", 4'(turno_p1), 4'd1);

        // Wrong player's flag during P1's turn
        p2_mm = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mal.turno_p1", 4'(turno_p1), 4'd1);
        chk("mal.jugadas", jugadas, 4'd1);
        p2_mm = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Move edge on the very cycle the timer expires
        nuevo();
        repeat (13) @(posedge clk);
        #1;
        cel[5] = 2'b11;
        p1_mm = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sim.tiempo", 4'(tiempo_agotado), 4'd0);
        chk("sim.turno_p1", 4'(turno_p1), 4'd0);
        chk("sim.turno_p2", 4'(turno_p2), 4'd0);
        @(posedge clk);
        #1;
        chk("sim.tiempo2", 4'(tiempo_agotado), 4'd0);
        @(posedge clk);
        #1;
        chk("sim.turno_p2_sig", 4'(turno_p2), 4'd1);
        chk("sim.jugadas", jugadas, 4'd1);
        p1_mm = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // New game requested while a move sits in ESPERA
        jugar(2, 2);
        chk("esp.jugadas_antes", jugadas, 4'd2);
        cel[3] = 2'b11;
        p1_mm = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("esp.en_espera", 4'(turno_p1), 4'd0);
        nuevo_juego = 1'b1;
        @(posedge clk);
        #1;
        nuevo_juego = 1'b0;
        chk("esp.turno_p1", 4'(turno_p1), 4'd1);
        chk("esp.turno_p2", 4'(turno_p2), 4'd0);
        chk_res("esp", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        p1_mm = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // P2 wins on column 2
        nuevo();
        jugar(1, 1); jugar(2, 2); jugar(4, 1); jugar(5, 2); jugar(9, 1); jugar(8, 2);
        chk_res("col2", 1'b0, 1'b1, 1'b0, 4'd5, 4'd6);

        // P1 wins the c3-c5-c7 diagonal on the 9th move
        nuevo();
        jugar(5, 1); jugar(1, 2); jugar(3, 1); jugar(2, 2); jugar(4, 1);
        jugar(6, 2); jugar(8, 1); jugar(9, 2); jugar(7, 1);
        chk_res("diag", 1'b1, 1'b0, 1'b0, 4'd8, 4'd9);

        // Flags ignored in FIN, then reset clears everything
        p2_mm = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("fin.turno_p2", 4'(turno_p2), 4'd0);
        chk_res("fin", 1'b1, 1'b0, 1'b0, 4'd8, 4'd9);
        p2_mm = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_fin.turno_p1", 4'(turno_p1), 4'd1);
        chk_res("rst_fin", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", pasado, total);
        $finish;
    end

endmodule
